regfile_sb: RTL and testbench

- Parametrised general-purpose register file for the datapath: two asynchronous read ports (S, T), one synchronous write port (D).
- Adds three things over the fixed 32x32 file:
  - same-cycle write-to-read bypass;
  - a per-register pending-write scoreboard, so the decode stage can detect load-use and multi-cycle hazards;
  - a sequenced full-file clear, so a soft restart can zero the file without asserting reset.
- Sits between decode (reads, reservations) and write-back (writes).

---
 rtl/regfile_sb_if.sv | 38 +++
 rtl/regfile_sb.sv | 117 +++++++++++
 tb/tb_regfile_sb.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/write-back side bundle of the
// scoreboarded register file (read, write, reserve, clear).
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              d_en;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d;
  logic [ADDR_W-1:0] s_addr;
  logic [ADDR_W-1:0] t_addr;
  logic [DATA_W-1:0] s;
  logic [DATA_W-1:0] t;
  logic              s_busy;
  logic              t_busy;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              clr_req;
  logic              clr_busy;

  modport master (
    output d_en, d_addr, d,
    output s_addr, t_addr,
    output rsv_en, rsv_addr,
    output clr_req,
    input  s, t, s_busy, t_busy,
    input  clr_busy
  );

  modport slave (
    input  d_en, d_addr, d,
    input  s_addr, t_addr,
    input  rsv_en, rsv_addr,
    input  clr_req,
    output s, t, s_busy, t_busy,
    output clr_busy
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with write bypass,
// pending-write scoreboard and a sequenced full clear.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [DEPTH-1:0] pend_q;

  logic idle;
  logic wr_ok;
  logic rsv_ok;
  logic s_zero;
  logic t_zero;
  logic s_byp;
  logic t_byp;

  assign idle   = (state_q == IDLE);
  assign wr_ok  = idle && bus.d_en &&
                  !(ZERO_REG && bus.d_addr == '0);
  assign rsv_ok = idle && bus.rsv_en &&
                  !(ZERO_REG && bus.rsv_addr == '0);
  assign s_zero = ZERO_REG && bus.s_addr == '0;
  assign t_zero = ZERO_REG && bus.t_addr == '0;
  assign s_byp  = wr_ok && bus.d_addr == bus.s_addr;
  assign t_byp  = wr_ok && bus.d_addr == bus.t_addr;

  // Read ports: zero reg, then bypass, then array
  always_comb begin
    bus.s      = mem_q[bus.s_addr];
    bus.t      = mem_q[bus.t_addr];
    bus.s_busy = pend_q[bus.s_addr];
    bus.t_busy = pend_q[bus.t_addr];
    if (s_byp) begin
      bus.s      = bus.d;
      bus.s_busy = 1'b0;
    end
    if (t_byp) begin
      bus.t      = bus.d;
      bus.t_busy = 1'b0;
    end
    if (s_zero) begin
      bus.s      = '0;
      bus.s_busy = 1'b0;
    end
    if (t_zero) begin
      bus.t      = '0;
      bus.t_busy = 1'b0;
    end
  end

  assign bus.clr_busy = (state_q == CLEAR);

  // Clear sequencer next state; index wraps at DEPTH
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Register array: sweep clears, else legal write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '0;
    end else if (!idle) begin
      mem_q[idx_q] <= '0;
    end else if (wr_ok) begin
      mem_q[bus.d_addr] <= bus.d;
    end
  end

  // Scoreboard: write retires, same-cycle reserve wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
    end else if (!idle) begin
      pend_q[idx_q] <= 1'b0;
    end else begin
      if (wr_ok)  pend_q[bus.d_addr]   <= 1'b0;
      if (rsv_ok) pend_q[bus.rsv_addr] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of bypass, scoreboard,
// clear sweep and reset on a default and a small instance.
module tb_regfile_sb;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;
  int   cnt;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus_a ();
  regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) bus_b ();

  regfile_sb #(
    .DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)
  ) u_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave)
  );

  regfile_sb #(
    .DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)
  ) u_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    bus_a.d_en = 0; bus_a.d_addr = 0; bus_a.d = 0;
    bus_a.s_addr = 0; bus_a.t_addr = 0;
    bus_a.rsv_en = 0; bus_a.rsv_addr = 0;
    bus_a.clr_req = 0;
    bus_b.d_en = 0; bus_b.d_addr = 0; bus_b.d = 0;
    bus_b.s_addr = 0; bus_b.t_addr = 0;
    bus_b.rsv_en = 0; bus_b.rsv_addr = 0;
    bus_b.clr_req = 0;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;

    // reset state
    for (int i = 0; i < 32; i++) begin
      bus_a.s_addr = 5'(i);
      bus_a.t_addr = 5'(31 - i);
      #1;
      chk("rst_s", bus_a.s, 0);
      chk("rst_t", bus_a.t, 0);
      chk("rst_sb", {31'd0, bus_a.s_busy}, 0);
      chk("rst_tb", {31'd0, bus_a.t_busy}, 0);
    end
    chk("rst_clr", {31'd0, bus_a.clr_busy}, 0);

    // plain write, read next cycle
    bus_a.d_en = 1; bus_a.d_addr = 5; bus_a.d = 32'hDEADBEEF;
    tick;
    bus_a.d_en = 0; bus_a.s_addr = 5;
    #1 chk("wr5", bus_a.s, 32'hDEADBEEF);

    // same-cycle bypass
    bus_a.d_en = 1; bus_a.d_addr = 7; bus_a.d = 32'h12345678;
    bus_a.s_addr = 7; bus_a.t_addr = 7;
    #1;
    chk("byp_s", bus_a.s, 32'h12345678);
    chk("byp_t", bus_a.t, 32'h12345678);
    tick;
    bus_a.d_en = 0;
    #1 chk("wr7", bus_a.s, 32'h12345678);

    // register 0 is hardwired
    bus_a.d_en = 1; bus_a.d_addr = 0; bus_a.d = 32'hFFFFFFFF;
    bus_a.s_addr = 0;
    #1 chk("r0_byp", bus_a.s, 0);
    tick;
    bus_a.d_en = 0;
    #1 chk("r0_wr", bus_a.s, 0);
    bus_a.rsv_en = 1; bus_a.rsv_addr = 0;
    tick;
    bus_a.rsv_en = 0;
    #1 chk("r0_busy", {31'd0, bus_a.s_busy}, 0);

    // scoreboard
    bus_a.rsv_en = 1; bus_a.rsv_addr = 9;
    bus_a.s_addr = 9; bus_a.t_addr = 9;
    #1 chk("rsv_pre", {31'd0, bus_a.s_busy}, 0);
    tick;
    bus_a.rsv_en = 0;
    #1;
    chk("rsv_s", {31'd0, bus_a.s_busy}, 1);
    chk("rsv_t", {31'd0, bus_a.t_busy}, 1);
    bus_a.d_en = 1; bus_a.d_addr = 9; bus_a.d = 32'h55;
    #1;
    chk("wb_byp_busy", {31'd0, bus_a.s_busy}, 0);
    chk("wb_byp_s", bus_a.s, 32'h55);
    tick;
    bus_a.d_en = 0;
    #1;
    chk("wb_busy", {31'd0, bus_a.s_busy}, 0);
    chk("wb_s", bus_a.s, 32'h55);
    bus_a.d_en = 1; bus_a.d = 32'h66;
    bus_a.rsv_en = 1; bus_a.rsv_addr = 9;
    tick;
    bus_a.d_en = 0; bus_a.rsv_en = 0;
    #1;
    chk("wr_rsv_busy", {31'd0, bus_a.s_busy}, 1);
    chk("wr_rsv_s", bus_a.s, 32'h66);

    // fill 1..31 then sweep
    for (int i = 1; i < 32; i++) begin
      bus_a.d_en = 1; bus_a.d_addr = 5'(i); bus_a.d = i;
      tick;
    end
    bus_a.d_en = 0; bus_a.s_addr = 31;
    #1 chk("fill31", bus_a.s, 31);
    bus_a.clr_req = 1;
    tick;
    bus_a.clr_req = 0;
    chk("clr_start", {31'd0, bus_a.clr_busy}, 1);
    cnt = 0;
    while (bus_a.clr_busy && cnt < 100) begin
      bus_a.d_en = 0;
      bus_a.clr_req = 0;
      if (cnt == 16) begin
        bus_a.d_en = 1; bus_a.d_addr = 3; bus_a.d = 32'hAA;
        bus_a.s_addr = 3; bus_a.t_addr = 20;
        #1;
        chk("mid_nobyp", bus_a.s, 0);
        chk("mid_r20", bus_a.t, 20);
      end
      if (cnt == 20) bus_a.clr_req = 1;
      cnt++;
      tick;
    end
    bus_a.d_en = 0; bus_a.clr_req = 0;
    chk("clr_len", cnt, 32);
    for (int i = 0; i < 32; i++) begin
      bus_a.s_addr = 5'(i);
      #1;
      chk("clr_s", bus_a.s, 0);
      chk("clr_sb", {31'd0, bus_a.s_busy}, 0);
    end

    // reset during a sweep
    bus_a.d_en = 1; bus_a.d_addr = 20; bus_a.d = 32'h20;
    tick;
    bus_a.d_en = 0;
    bus_a.rsv_en = 1; bus_a.rsv_addr = 20;
    tick;
    bus_a.rsv_en = 0;
    bus_a.clr_req = 1;
    tick;
    bus_a.clr_req = 0;
    repeat (10) tick;
    bus_a.s_addr = 20;
    #1;
    chk("mid_busy", {31'd0, bus_a.clr_busy}, 1);
    chk("mid_r20b", bus_a.s, 32'h20);
    chk("mid_p20", {31'd0, bus_a.s_busy}, 1);
    reset = 1'b1;
    #1;
    chk("rstm_clr", {31'd0, bus_a.clr_busy}, 0);
    chk("rstm_s", bus_a.s, 0);
    chk("rstm_sb", {31'd0, bus_a.s_busy}, 0);
    tick;
    reset = 1'b0;

    // small instance without zero register
    bus_b.d_en = 1; bus_b.d_addr = 0; bus_b.d = 16'hBEEF;
    bus_b.s_addr = 0;
    #1 chk("b_byp", {16'd0, bus_b.s}, 32'hBEEF);
    tick;
    bus_b.d_en = 0;
    bus_b.rsv_en = 1; bus_b.rsv_addr = 0;
    #1 chk("b_r0", {16'd0, bus_b.s}, 32'hBEEF);
    tick;
    bus_b.rsv_en = 0;
    #1 chk("b_r0_busy", {31'd0, bus_b.s_busy}, 1);
    bus_b.clr_req = 1;
    tick;
    bus_b.clr_req = 0;
    cnt = 0;
    while (bus_b.clr_busy && cnt < 100) begin
      cnt++;
      tick;
    end
    chk("b_clr_len", cnt, 8);
    chk("b_clr_s", {16'd0, bus_b.s}, 0);
    chk("b_clr_sb", {31'd0, bus_b.s_busy}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
